// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl
// Turns the debounced switch presses into a roll request for one of four dice,
// steps the dice LFSR, rejection-samples its value into 1..N, plays a short
// animation of ROLL_FRAMES values, then holds the final value as BCD digits.

module dice_roll_ctrl #(
  parameter int CLKS_PER_FRAME = 2500000,
  parameter int ROLL_FRAMES    = 12
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  input  logic [4:0] i_Rand,
  output logic       o_Lfsr_En,
  output logic [1:0] o_Die_Sel,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones,
  output logic       o_Blank,
  output logic       o_Rolling,
  output logic       o_Done
);

  // Sequencer states
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SAMPLE     = 2'd1;
  localparam logic [1:0] HOLD_FRAME = 2'd2;
  localparam logic [1:0] SHOW       = 2'd3;

  // Die select encoding
  localparam logic [1:0] DIE_D4  = 2'd0;
  localparam logic [1:0] DIE_D6  = 2'd1;
  localparam logic [1:0] DIE_D8  = 2'd2;
  localparam logic [1:0] DIE_D20 = 2'd3;

  localparam int TIMER_W = (CLKS_PER_FRAME > 2) ? $clog2(CLKS_PER_FRAME) : 1;
  localparam int COUNT_W = $clog2(ROLL_FRAMES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_FRAME - 1);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(ROLL_FRAMES);

  // Switch edge detection
  logic [3:0]         r_SwLevel;
  logic [3:0]         r_SwPrev;
  logic [3:0]         w_Press;
  logic               w_PressValid;
  logic [1:0]         w_PressDie;

  // Sequencer and roll bookkeeping
  logic [1:0]         r_State;
  logic [1:0]         w_NextState;
  logic [1:0]         r_DieSel;
  logic [COUNT_W-1:0] r_FrameCnt;
  logic [COUNT_W-1:0] w_FrameCntInc;
  logic [TIMER_W-1:0] r_Timer;
  logic               w_TimerDone;

  // Sampling datapath
  logic [4:0]         w_Mask;
  logic [4:0]         w_Limit;
  logic [4:0]         w_Masked;
  logic [4:0]         w_SampleValue;
  logic               w_Accept;
  logic               w_LastFrame;
  logic [3:0]         w_Tens;
  logic [3:0]         w_Ones;

  // Registered outputs
  logic [3:0]         r_Tens;
  logic [3:0]         r_Ones;
  logic               r_Blank;
  logic               r_LfsrEn;
  logic               r_Rolling;
  logic               r_Done;

  // A press is a rising level seen by the registered switch copy. Both the
  // level and previous-level registers reset high so a switch held through
  // reset looks like it has always been pressed and never fires.
  assign w_Press      = r_SwLevel & ~r_SwPrev;
  assign w_PressValid = (|w_Press) && ((r_State == IDLE) || (r_State == SHOW));

  // Fixed priority: Switch_1 wins, lower-priority simultaneous presses drop
  always_comb begin
    w_PressDie = DIE_D4;
    if (w_Press[0]) begin
      w_PressDie = DIE_D4;
    end else if (w_Press[1]) begin
      w_PressDie = DIE_D6;
    end else if (w_Press[2]) begin
      w_PressDie = DIE_D8;
    end else if (w_Press[3]) begin
      w_PressDie = DIE_D20;
    end
  end

  // Sample mask and acceptance limit for the latched die
  always_comb begin
    w_Mask  = 5'b11111;
    w_Limit = 5'd20;
    case (r_DieSel)
      DIE_D4: begin
        w_Mask  = 5'b00011;
        w_Limit = 5'd4;
      end
      DIE_D6: begin
        w_Mask  = 5'b00111;
        w_Limit = 5'd6;
      end
      DIE_D8: begin
        w_Mask  = 5'b00111;
        w_Limit = 5'd8;
      end
      default: begin
        w_Mask  = 5'b11111;
        w_Limit = 5'd20;
      end
    endcase
  end

  assign w_Masked      = i_Rand & w_Mask;
  assign w_SampleValue = w_Masked + 5'd1;
  assign w_Accept      = (r_State == SAMPLE) && (w_Masked < w_Limit);
  assign w_FrameCntInc = r_FrameCnt + COUNT_W'(1);
  assign w_LastFrame   = (w_FrameCntInc == COUNT_LAST);
  assign w_TimerDone   = (r_Timer == TIMER_LAST);

  // Split an accepted sample (1..20) into BCD tens and ones digits
  always_comb begin
    w_Tens = 4'd0;
    w_Ones = 4'(w_SampleValue);
    if (w_SampleValue >= 5'd20) begin
      w_Tens = 4'd2;
      w_Ones = 4'(w_SampleValue - 5'd20);
    end else if (w_SampleValue >= 5'd10) begin
      w_Tens = 4'd1;
      w_Ones = 4'(w_SampleValue - 5'd10);
    end
  end

  // Next-state selection for the roll sequencer
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      IDLE, SHOW: begin
        if (w_PressValid) begin
          w_NextState = SAMPLE;
        end
      end
      SAMPLE: begin
        if (w_Accept) begin
          w_NextState = w_LastFrame ? SHOW : HOLD_FRAME;
        end
      end
      HOLD_FRAME: begin
        if (w_TimerDone) begin
          w_NextState = SAMPLE;
        end
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase
  end

  // Register switch levels for press detection
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_SwLevel <= 4'b1111;
      r_SwPrev  <= 4'b1111;
    end else begin
      r_SwLevel <= {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
      r_SwPrev  <= r_SwLevel;
    end
  end

  // Sequencer state register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Latch die choice, count accepted frames and time the hold between them
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_DieSel   <= DIE_D4;
      r_FrameCnt <= '0;
      r_Timer    <= '0;
    end else begin
      if (w_PressValid) begin
        r_DieSel   <= w_PressDie;
        r_FrameCnt <= '0;
        r_Timer    <= '0;
      end else if (w_Accept) begin
        r_FrameCnt <= w_FrameCntInc;
        r_Timer    <= '0;
      end else if (r_State == HOLD_FRAME) begin
        if (w_TimerDone) begin
          r_Timer <= '0;
        end else begin
          r_Timer <= r_Timer + TIMER_W'(1);
        end
      end
    end
  end

  // Update the displayed digits on every accepted sample
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Tens  <= 4'd0;
      r_Ones  <= 4'd0;
      r_Blank <= 1'b1;
    end else if (w_Accept) begin
      r_Tens  <= w_Tens;
      r_Ones  <= w_Ones;
      r_Blank <= 1'b0;
    end
  end

  // Status outputs registered from the state being entered
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_LfsrEn  <= 1'b0;
      r_Rolling <= 1'b0;
      r_Done    <= 1'b0;
    end else begin
      r_LfsrEn  <= (w_NextState == SAMPLE) || (w_NextState == HOLD_FRAME);
      r_Rolling <= (w_NextState == SAMPLE) || (w_NextState == HOLD_FRAME);
      r_Done    <= w_Accept && w_LastFrame;
    end
  end

  assign o_Lfsr_En = r_LfsrEn;
  assign o_Die_Sel = r_DieSel;
  assign o_Tens    = r_Tens;
  assign o_Ones    = r_Ones;
  assign o_Blank   = r_Blank;
  assign o_Rolling = r_Rolling;
  assign o_Done    = r_Done;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb_dice_roll_ctrl
// Directed vector table plus hand-written sequences for the dice sequencer,
// followed by random stimulus compared cycle by cycle against an event-level
// model of a roll.

module tb_dice_roll_ctrl;

  localparam int CLKS_PER_FRAME = 4;
  localparam int ROLL_FRAMES    = 3;

  typedef struct packed {
    bit       lfsrEn;
    bit [1:0] dieSel;
    bit [3:0] tens;
    bit [3:0] ones;
    bit       blank;
    bit       rolling;
    bit       done;
  } outs_t;

  typedef struct {
    string    name;
    bit       rstN;
    bit [3:0] sw;
    bit [4:0] rnd;
    outs_t    exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [3:0] sw;
  logic [4:0] rnd;

  logic       lfsrEn;
  logic [1:0] dieSel;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank;
  logic       rolling;
  logic       done;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  // Reference model of a roll: die, accepted frames, cycles of hold left
  int       mDie;
  int       mFrames;
  int       mHoldLeft;
  int       mValue;
  int       mPending;
  bit       mSampling;
  bit       mEverShown;
  bit       mDone;
  bit [3:0] mLastSw;

  dice_roll_ctrl #(
    .CLKS_PER_FRAME(CLKS_PER_FRAME),
    .ROLL_FRAMES   (ROLL_FRAMES)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rstN),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .i_Rand    (rnd),
    .o_Lfsr_En (lfsrEn),
    .o_Die_Sel (dieSel),
    .o_Tens    (tens),
    .o_Ones    (ones),
    .o_Blank   (blank),
    .o_Rolling (rolling),
    .o_Done    (done)
  );

  always #5 clk = ~clk;

  function automatic int sidesOf(int die);
    case (die)
      0:       return 4;
      1:       return 6;
      2:       return 8;
      default: return 20;
    endcase
  endfunction

  // Power-of-two span the LFSR value is folded into before the range test
  function automatic int spanOf(int die);
    case (die)
      0:       return 4;
      1, 2:    return 8;
      default: return 32;
    endcase
  endfunction

  function automatic outs_t mkOuts(bit l, bit [1:0] d, bit [3:0] t, bit [3:0] o,
                                   bit b, bit r, bit dn);
    outs_t x;
    x.lfsrEn  = l;
    x.dieSel  = d;
    x.tens    = t;
    x.ones    = o;
    x.blank   = b;
    x.rolling = r;
    x.done    = dn;
    return x;
  endfunction

  function automatic outs_t resetOuts();
    return mkOuts(1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic outs_t dutOuts();
    return mkOuts(lfsrEn, dieSel, tens, ones, blank, rolling, done);
  endfunction

  function automatic outs_t modelOuts();
    bit busy;
    busy = mSampling || (mHoldLeft > 0);
    return mkOuts(busy, 2'(mDie), 4'(mValue / 10), 4'(mValue % 10),
                  !mEverShown, busy, mDone);
  endfunction

  task automatic modelReset();
    mDie       = 0;
    mFrames    = 0;
    mHoldLeft  = 0;
    mValue     = 0;
    mPending   = -1;
    mSampling  = 1'b0;
    mEverShown = 1'b0;
    mDone      = 1'b0;
    mLastSw    = 4'b1111;
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic modelStep();
    int sample;
    if (!rstN) begin
      modelReset();
      return;
    end
    mDone = 1'b0;
    if (mSampling) begin
      sample = int'(rnd) % spanOf(mDie);
      if (sample < sidesOf(mDie)) begin
        mValue     = sample + 1;
        mEverShown = 1'b1;
        mFrames    = mFrames + 1;
        mSampling  = 1'b0;
        if (mFrames == ROLL_FRAMES) mDone = 1'b1;
        else mHoldLeft = CLKS_PER_FRAME;
      end
    end else if (mHoldLeft > 0) begin
      mHoldLeft = mHoldLeft - 1;
      if (mHoldLeft == 0) mSampling = 1'b1;
    end else if (mPending >= 0) begin
      mDie      = mPending;
      mFrames   = 0;
      mSampling = 1'b1;
    end
    mPending = -1;
    for (int i = 0; i < 4; i++) begin
      if (mPending < 0 && sw[i] && !mLastSw[i]) mPending = i;
    end
    mLastSw = sw;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act   = dutOuts();
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got lfsr=%0b die=%0d tens=%0d ones=%0d blank=%0b roll=%0b done=%0b, want lfsr=%0b die=%0d tens=%0d ones=%0d blank=%0b roll=%0b done=%0b",
               name, act.lfsrEn, act.dieSel, act.tens, act.ones, act.blank, act.rolling, act.done,
               exp.lfsrEn, exp.dieSel, exp.tens, exp.ones, exp.blank, exp.rolling, exp.done);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    total = total + 1;
    if (got != want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, advance the model on the
  // rising edge and compare every output against it shortly after
  task automatic applyStimulus(input bit r, input bit [3:0] s, input bit [4:0] v);
    @(negedge clk);
    rstN = r;
    sw   = s;
    rnd  = v;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("model", modelOuts());
  endtask

  function automatic void addVec(string name, bit r, bit [3:0] s, bit [4:0] v,
                                 bit l, bit [1:0] d, bit [3:0] t, bit [3:0] o,
                                 bit b, bit ro, bit dn);
    vec_t x;
    x.name = name;
    x.rstN = r;
    x.sw   = s;
    x.rnd  = v;
    x.exp  = mkOuts(l, d, t, o, b, ro, dn);
    vecs.push_back(x);
  endfunction

  initial begin
    int changes;
    int doneCnt;
    int dieBad;
    int rv;
    bit seen;
    bit [7:0] prevDisp;
    bit [3:0] rsw;

    rstN = 1'b0;
    sw   = 4'b0010;
    rnd  = 5'd0;
    modelReset();

    // d6 rejection then a full roll, followed by d20 boundaries from SHOW
    addVec("d6_release",   1, 4'b0000, 0,  0, 0, 0, 0, 1, 0, 0);
    addVec("d6_press",     1, 4'b0010, 0,  0, 0, 0, 0, 1, 0, 0);
    addVec("d6_enter",     1, 4'b0010, 0,  1, 1, 0, 0, 1, 1, 0);
    addVec("d6_rej6",      1, 4'b0010, 6,  1, 1, 0, 0, 1, 1, 0);
    addVec("d6_rej7",      1, 4'b0000, 7,  1, 1, 0, 0, 1, 1, 0);
    addVec("d6_acc2",      1, 4'b0000, 2,  1, 1, 0, 3, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      addVec("d6_hold1",   1, 4'b0000, 0,  1, 1, 0, 3, 0, 1, 0);
    addVec("d6_acc_f2",    1, 4'b0000, 0,  1, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      addVec("d6_hold2",   1, 4'b0000, 0,  1, 1, 0, 1, 0, 1, 0);
    addVec("d6_final",     1, 4'b0000, 5,  0, 1, 0, 6, 0, 0, 1);
    addVec("d6_show",      1, 4'b0000, 0,  0, 1, 0, 6, 0, 0, 0);
    addVec("d20_press",    1, 4'b1000, 0,  0, 1, 0, 6, 0, 0, 0);
    addVec("d20_enter",    1, 4'b1000, 0,  1, 3, 0, 6, 0, 1, 0);
    addVec("d20_rej20",    1, 4'b1000, 20, 1, 3, 0, 6, 0, 1, 0);
    addVec("d20_acc19",    1, 4'b1000, 19, 1, 3, 2, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      addVec("d20_hold1",  1, 4'b1000, 0,  1, 3, 2, 0, 0, 1, 0);
    addVec("d20_acc9",     1, 4'b1000, 9,  1, 3, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      addVec("d20_hold2",  1, 4'b1000, 31, 1, 3, 1, 0, 0, 1, 0);
    addVec("d20_acc0",     1, 4'b1000, 0,  0, 3, 0, 1, 0, 0, 1);
    addVec("d20_show",     1, 4'b1000, 0,  0, 3, 0, 1, 0, 0, 0);

    // Reset with Switch_2 held through release: nothing may start
    applyStimulus(1'b0, 4'b0010, 5'd0);
    applyStimulus(1'b0, 4'b0010, 5'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'b0010, 5'(i));
      checkOutput("reset_hold", resetOuts());
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].sw, vecs[i].rnd);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Arbitration: Switch_1 and Switch_4 together pick d4; Switch_3 during
    // the hold is ignored; three values appear and Done pulses once
    applyStimulus(1'b1, 4'b0000, 5'd0);
    applyStimulus(1'b1, 4'b1001, 5'd0);
    applyStimulus(1'b1, 4'b1001, 5'd0);
    checkValue("arb_die", int'(dieSel), 0);
    checkValue("arb_rolling", int'(rolling), 1);
    changes  = 0;
    doneCnt  = 0;
    dieBad   = 0;
    prevDisp = {tens, ones};
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, (i >= 2 && i < 6) ? 4'b0100 : 4'b0000, 5'(changes + 1));
      if ({tens, ones} != prevDisp) changes = changes + 1;
      prevDisp = {tens, ones};
      if (done) doneCnt = doneCnt + 1;
      if (dieSel != 2'd0) dieBad = dieBad + 1;
    end
    checkValue("arb_values_shown", changes, 3);
    checkValue("arb_done_pulses", doneCnt, 1);
    checkValue("arb_die_kept", dieBad, 0);
    checkOutput("arb_final", mkOuts(1'b0, 2'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0));

    // Reset during HOLD_FRAME abandons the roll
    applyStimulus(1'b1, 4'b0001, 5'd0);
    applyStimulus(1'b1, 4'b0001, 5'd0);
    applyStimulus(1'b1, 4'b0000, 5'd2);
    applyStimulus(1'b1, 4'b0000, 5'd0);
    checkOutput("mid_hold", mkOuts(1'b1, 2'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0));
    applyStimulus(1'b0, 4'b0000, 5'd0);
    checkOutput("mid_reset", resetOuts());
    applyStimulus(1'b1, 4'b0000, 5'd0);

    // Restart from SHOW after a completed d6 roll
    applyStimulus(1'b1, 4'b0010, 5'd0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      applyStimulus(1'b1, 4'b0000, 5'd0);
      if (done) seen = 1'b1;
    end
    checkValue("restart_wait_done", int'(seen), 1);
    applyStimulus(1'b1, 4'b0000, 5'd0);
    applyStimulus(1'b1, 4'b0100, 5'd4);
    checkOutput("restart_edge1", mkOuts(1'b0, 2'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b1, 4'b0100, 5'd4);
    checkOutput("restart_edge2", mkOuts(1'b1, 2'd2, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0));
    applyStimulus(1'b1, 4'b0100, 5'd4);
    checkOutput("restart_acc", mkOuts(1'b1, 2'd2, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0));

    // Random switches, LFSR values and occasional resets against the model
    rsw = 4'b0100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        rv  = $urandom_range(0, 3);
        rsw = rsw ^ (4'b0001 << rv);
      end
      applyStimulus(($urandom_range(0, 299) != 0), rsw, 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Sequencer for the dice game datapath. It arbitrates the four debounced switches into a roll request for one of four die types (d4, d6, d8, d20) and steps the dice LFSR. It rejection-samples the LFSR output into the range 1..N and plays a fixed-length roll animation. It then holds the final value as two BCD digits for the two Binary_to_7Segment instances.

## Interface
Parameters:
- CLKS_PER_FRAME, 2500000: clocks each animation value is held (100 ms at 25 MHz); must be ≥ 2.
- ROLL_FRAMES, 12: number of accepted samples per roll, the last one being the result; must be ≥ 1.

Ports:
- i_Clk  in  1  system clock; one clock domain.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_Switch_1 .. i_Switch_4  in  1 each  debounced switch levels, high = pressed; request d4, d6, d8, d20 respectively.
- i_Rand  in  5  current dice LFSR state; advances one step per cycle in which o_Lfsr_En is high.
- o_Lfsr_En  out  1  LFSR step enable.
- o_Die_Sel  out  2  die of current/last roll: 0=d4, 1=d6, 2=d8, 3=d20.
- o_Tens  out  4  BCD tens digit of displayed value (0..2).
- o_Ones  out  4  BCD ones digit (0..9).
- o_Blank  out  1  high = display off.
- o_Rolling  out  1  high while the animation runs.
- o_Done  out  1  one-cycle pulse when the final value is shown.

## Operation
- States: IDLE, SAMPLE, HOLD_FRAME, SHOW.
- Press detect: a per-switch previous-level register; press = level & ~prev. Prev registers reset to 1, so a switch held through reset never triggers.
- Arbitration: presses are honoured only in IDLE and SHOW. Fixed priority is Switch_1 > 2 > 3 > 4; lower-priority simultaneous presses are dropped. Presses in SAMPLE or HOLD_FRAME are dropped and not queued.
- On an accepted press: latch o_Die_Sel, clear the frame count, go to SAMPLE. The displayed value is unchanged until the first sample is accepted.
- SAMPLE, each cycle: compute masked = i_Rand & mask, where the mask is 2'b11 for d4, 3'b111 for d6/d8, and 5'b11111 for d20.
  - Accept if masked < N, with N = 4, 6, 8, 20. Otherwise stay in SAMPLE; the LFSR has stepped, so the next cycle retries.
  - On accept: load value = masked + 1 and increment the frame count.
  - If the count reaches ROLL_FRAMES, go to SHOW. Otherwise go to HOLD_FRAME with the frame timer cleared.
- HOLD_FRAME: the timer counts 0..CLKS_PER_FRAME-1, then the state returns to SAMPLE.
- o_Lfsr_En = 1 in SAMPLE and HOLD_FRAME, 0 in IDLE and SHOW.
- o_Rolling = 1 in SAMPLE and HOLD_FRAME.
- SHOW: holds the value until the next accepted press, which restarts the roll.
- BCD conversion: tens = 2 if value ≥ 20, 1 if ≥ 10, else 0; ones = value − 10·tens.
- o_Blank = 1 from reset until the first accepted sample, 0 thereafter.

## Timing
- Reset values: state IDLE, o_Lfsr_En 0, o_Die_Sel 0, o_Tens 0, o_Ones 0, o_Blank 1, o_Rolling 0, o_Done 0, frame count 0, timer 0.
- Reset asserted in any state returns the block to the reset values on the next edge; any roll in progress is abandoned.
- All outputs are registered.
- A switch rising and sampled high at edge t puts the block in SAMPLE after edge t+1, where o_Lfsr_En and o_Rolling go high.
- An accept in the cycle ending at edge a gives new o_Tens/o_Ones and o_Blank = 0 after edge a.
- HOLD_FRAME lasts exactly CLKS_PER_FRAME cycles.
- The final accept at edge a gives state SHOW, o_Done = 1, and o_Rolling = 0 after edge a. o_Done returns to 0 at edge a+1.
- A roll is at least ROLL_FRAMES + (ROLL_FRAMES−1)·CLKS_PER_FRAME cycles, plus one cycle per rejected sample.
- Value range is invariant: 1 ≤ value ≤ N for the latched die.

## Test plan
Use CLKS_PER_FRAME = 4, ROLL_FRAMES = 3, and drive i_Rand directly from the bench.
- Reset with i_Switch_2 held high through release: no roll occurs. All outputs hold reset values, including o_Blank = 1 and o_Lfsr_En = 0, for 20 cycles.
- d6 rejection: press Switch_2, then drive i_Rand 6, 7, 2. The first two samples are rejected (stay in SAMPLE). The third is accepted: o_Ones = 3, o_Tens = 0, and HOLD_FRAME lasts 4 cycles.
- d20 boundaries: press Switch_4 with i_Rand 20, then 19. 20 is rejected; 19 gives o_Tens = 2, o_Ones = 0. Then i_Rand 9 gives o_Tens = 1, o_Ones = 0. A third sample of 0 gives o_Tens = 0, o_Ones = 1, and o_Done pulses once.
- Arbitration: Switch_1 and Switch_4 rise in the same cycle, giving o_Die_Sel = 0. Switch_3 pressed during HOLD_FRAME has no effect. Exactly 3 values are shown; o_Done is high for exactly 1 cycle.
- Reset mid-roll: assert i_Rst_L = 0 during HOLD_FRAME. After the next edge the state is IDLE, o_Rolling = 0, o_Blank = 1, and o_Tens/o_Ones = 0.
- Restart from SHOW: Switch_3 pressed after a completed roll gives o_Die_Sel = 2 and o_Rolling = 1 two edges after the press. The old value remains displayed until the first new accept.
